// File: rtl/i_decode.sv
// i_decode: decode stage with 16x32 register file, write-before-read bypass and local branch resolution
module i_decode #(
    parameter int NREGS = 16,
    parameter bit TRACE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_async,
    input  logic [31:0]              instruction,
    input  logic                     cond_flag,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_reg,
    input  logic [31:0]              wb_value,
    output logic                     load_en,
    output logic                     load_offset,
    output logic [19:0]              load_address,
    output logic                     dec_valid,
    output logic [3:0]               dec_opcode,
    output logic [3:0]               dec_rd,
    output logic [31:0]              dec_a,
    output logic [31:0]              dec_b
);
    localparam int IW = $clog2(NREGS);
    localparam logic [3:0] OPC_ARITH  = 4'h0;
    localparam logic [3:0] OPC_AR_IM  = 4'h1;
    localparam logic [3:0] OPC_TEST   = 4'h2;
    localparam logic [3:0] OPC_TS_IM  = 4'h3;
    localparam logic [3:0] OPC_LOAD   = 4'h4;
    localparam logic [3:0] OPC_STORE  = 4'h5;
    localparam logic [3:0] OPC_JUMP   = 4'h6;
    localparam logic [3:0] OPC_BRANCH = 4'h7;
    localparam logic [3:0] OPC_BR_CND = 4'h8;
    localparam logic [3:0] OPC_NOOP   = 4'hf;

    typedef enum logic [1:0] {IDLE, RESOLVE, HOLD} state_t;

    state_t        state, state_nx;
    logic [1:0]    hold_cnt, hold_nx;
    logic [31:0]   rf [NREGS];
    logic [3:0]    opc;
    logic [IW-1:0] rs1, rs2;
    logic [31:0]   src_a, src_b;
    logic          is_exec, is_imm, is_ctrl, illegal, take;
    logic          pend_cnd, pend_off, last_off;
    logic [19:0]   pend_addr, last_addr;
    logic [31:0]   dec_count, br_count, ill_count;

    assign opc     = instruction[31:28];
    assign rs1     = instruction[20 +: IW];
    assign rs2     = instruction[16 +: IW];
    assign is_exec = opc inside {OPC_ARITH, OPC_AR_IM, OPC_TEST, OPC_TS_IM, OPC_LOAD, OPC_STORE};
    assign is_imm  = opc inside {OPC_AR_IM, OPC_TS_IM, OPC_LOAD, OPC_STORE};
    assign is_ctrl = opc inside {OPC_JUMP, OPC_BRANCH, OPC_BR_CND};
    assign illegal = !is_exec && !is_ctrl && opc != OPC_NOOP;

    // a same-cycle writeback to a source register is seen by the read; r0 is hardwired to zero
    assign src_a = rs1 == '0 ? 32'h0 : (wb_en && wb_reg == rs1) ? wb_value : rf[rs1];
    assign src_b = rs2 == '0 ? 32'h0 : (wb_en && wb_reg == rs2) ? wb_value : rf[rs2];

    // redirect is only driven while resolving; otherwise the last issued target is held
    assign load_en      = take;
    assign load_offset  = take ? pend_off : last_off;
    assign load_address = take ? pend_addr : last_addr;

    // register file write port; writes accepted in every FSM state
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_en && wb_reg != '0) begin
            rf[wb_reg] <= wb_value;
        end
    end

    // branch window state register
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state    <= IDLE;
            hold_cnt <= 2'd0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    // one RESOLVE cycle, then three HOLD cycles covering fetch's NOP window
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        take     = 1'b0;
        case (state)
            IDLE:    state_nx = is_ctrl ? RESOLVE : IDLE;
            RESOLVE: begin
                take     = !pend_cnd || cond_flag;
                state_nx = HOLD;
                hold_nx  = 2'd2;
            end
            HOLD: begin
                hold_nx  = hold_cnt - 2'd1;
                state_nx = hold_cnt == 2'd0 ? IDLE : HOLD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // decoded bundle, pending branch capture and statistics counters
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            dec_valid  <= 1'b0;
            dec_opcode <= 4'hf;
            dec_rd     <= 4'h0;
            dec_a      <= 32'h0;
            dec_b      <= 32'h0;
            pend_cnd   <= 1'b0;
            pend_off   <= 1'b0;
            pend_addr  <= 20'h0;
            last_off   <= 1'b0;
            last_addr  <= 20'h0;
            dec_count  <= 32'h0;
            br_count   <= 32'h0;
            ill_count  <= 32'h0;
        end else begin
            dec_valid <= is_exec;
            if (is_exec) begin
                dec_opcode <= opc;
                dec_rd     <= instruction[27:24];
                dec_a      <= src_a;
                dec_b      <= is_imm ? {16'h0, instruction[15:0]} : src_b;
                dec_count  <= dec_count + 32'd1;
            end
            if (state == IDLE && is_ctrl) begin
                pend_cnd  <= opc == OPC_BR_CND;
                pend_off  <= opc != OPC_JUMP;
                pend_addr <= instruction[19:0];
            end
            if (take) begin
                last_off  <= pend_off;
                last_addr <= pend_addr;
                br_count  <= br_count + 32'd1;
            end
            if (illegal) ill_count <= ill_count + 32'd1;
        end
    end

`ifndef SYNTHESIS
    // simulation-only warnings and optional per-instruction trace
    always @(posedge clk) begin
        if (!rst_async) begin
            if (illegal) $display("i_decode warning: illegal opcode %h treated as NOP at %0t", opc, $time);
            if (is_ctrl && state != IDLE) $display("i_decode warning: control opcode %h ignored inside branch window at %0t", opc, $time);
            if (TRACE && opc != OPC_NOOP) $display("i_decode trace: %h at %0t", instruction, $time);
        end
    end

    final $display("i_decode: %0d decoded, %0d branches taken, %0d illegal", dec_count, br_count, ill_count);
`endif
endmodule

// File: doc/i_decode.md
Name: i_decode

Overview:
- Decode stage directly downstream of instruction fetch.
- Each cycle it consumes the 32-bit instruction word from fetch and reads operands from an internal 16x32 register file (write port driven by writeback).
- Presents a registered decoded bundle to execute.
- Resolves branch/jump opcodes locally and drives fetch's load_en/load_offset/load_address during fetch's 4-cycle NOP window.

Parameters:
- NREGS, 16, number of architectural registers (index width = $clog2(NREGS) = 4)
- TRACE, 0, when 1 print one $display line per decoded non-NOP instruction

Ports:
- clk  input  1  clock
- rst_async  input  1  asynchronous reset, active-high
- instruction  input  32  word from fetch; 'hf000_0000 = NOP
- cond_flag  input  1  result flag of the most recent TEST/TS_IM from execute
- wb_en  input  1  register write enable from writeback
- wb_reg  input  4  write index
- wb_value  input  32  write data
- load_en  output  1  one-cycle pulse to fetch: redirect PC
- load_offset  output  1  1 = PC-relative redirect, 0 = absolute
- load_address  output  20  target address or signed offset
- dec_valid  output  1  decoded bundle valid (0 for NOP and branch)
- dec_opcode  output  4  instruction[31:28]
- dec_rd  output  4  instruction[27:24]
- dec_a  output  32  value of register instruction[23:20]
- dec_b  output  32  value of register instruction[19:16] for register forms; zero-extended instruction[15:0] for AR_IM, TS_IM, LOAD, STORE

Behaviour:
- Reset (async, any cycle): all outputs 0; dec_opcode = 4'hf; register file cleared to 0; decoded counter 0. A branch pending at reset is dropped and no load_en is issued.
- Latency: one cycle. Outputs are registered from the instruction presented at the preceding clk edge.
- Opcode classes, using the types.sv macros:
  - Execute class: OPC_ARITH, OPC_AR_IM, OPC_TEST, OPC_TS_IM, OPC_LOAD, OPC_STORE → dec_valid=1.
  - OPC_NOOP → dec_valid=0, other outputs unchanged.
  - OPC_JUMP, OPC_BRANCH, OPC_BR_CND → control class, dec_valid=0.
  - Any other opcode → treated as NOOP; increments an illegal counter; $display warning.
- Register file read and bypass:
  - Combinational read of both sources.
  - If wb_en and wb_reg matches a source index in the same cycle, that source sees wb_value (write-before-read).
  - Register 0 reads as 0; writes to it are ignored.
- Control class:
  - Fetch has already advanced its counter to branch_addr+1 and enters its 4-NOP stall.
  - Decode state machine: IDLE → RESOLVE (1 cycle) → HOLD (3 cycles) → IDLE.
  - In RESOLVE, load_en pulses high for exactly one cycle:
    - OPC_JUMP: load_offset=0, load_address=instruction[19:0].
    - OPC_BRANCH: load_offset=1, load_address=instruction[19:0], a two's-complement offset added mod 2^20 by fetch.
    - OPC_BR_CND: as OPC_BRANCH if cond_flag=1 sampled in RESOLVE; else load_en stays 0 (fall through).
  - In HOLD, any incoming word (fetch supplies NOPs) is decoded normally; a control opcode arriving in HOLD is ignored and flagged.
  - Returning to IDLE coincides with fetch releasing its stall on the 5th cycle.
- load_address is held stable outside the pulse (last value); load_offset likewise.
- wb writes are accepted in every state, including RESOLVE and HOLD.
- Counters (32-bit, wrap): decoded instructions with dec_valid=1; branches taken. Both are printed in a final block.

Test Plan:
- Reset mid-stream: assert rst_async during RESOLVE of a JUMP → load_en never pulses; dec_opcode=4'hf, dec_valid=0, all registers read 0.
- Write then read: wb_en=1, wb_reg=3, wb_value=32'hdead_beef in the same cycle as an ARITH with rs1=3 → next cycle dec_a=32'hdead_beef, dec_valid=1.
- Immediate form: AR_IM with instruction[15:0]=16'h8001 → dec_b=32'h0000_8001; register-form ARITH with rs2=0 → dec_b=0.
- Absolute jump: JUMP target 20'h00123 → load_en high exactly one cycle after, load_offset=0, load_address=20'h00123; load_en low for the following 3 HOLD cycles.
- Conditional branch: BR_CND offset 20'hffffe with cond_flag=1 → load_en pulse, load_offset=1, load_address=20'hffffe. Repeat with cond_flag=0 → no pulse, FSM still spends 4 cycles.
- NOP and illegal: 'hf000_0000 → dec_valid=0 and valid counter unchanged; undefined opcode → dec_valid=0 and illegal counter +1.
